// File: rtl/fifo_drain_serializer.sv
// fifo_drain_serializer: read-side master for the flop-chain FIFO.
// Pops one word at a time and streams it out as out_bits chunks, LSB first.
//
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   enable         permits new pops; a word already in flight always completes
//   fifo_pndng     FIFO holds at least one word
//   fifo_dout      FIFO read data, valid the cycle after fifo_pop
//   fifo_pop       combinational single-cycle pop strobe
//   m_data/m_valid/m_ready/m_last  downstream chunk stream
//   words_read     count of fully transmitted words (wraps)
//   busy           high whenever a word is being fetched or sent
module fifo_drain_serializer #(
    parameter int bits      = 32,
    parameter int out_bits  = 8,
    parameter int cnt_width = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 fifo_pndng,
    input  logic [bits-1:0]      fifo_dout,
    output logic                 fifo_pop,
    output logic [out_bits-1:0]  m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last,
    output logic [cnt_width-1:0] words_read,
    output logic                 busy
);

    localparam int N  = bits / out_bits;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] SEND  = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [bits-1:0]      shreg_q, shreg_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [cnt_width-1:0] words_q, words_d;

    logic last_chunk;
    logic hs;
    logic can_pop;

    assign last_chunk = (idx_q == LAST_IDX);
    assign m_valid    = (state_q == SEND);
    assign hs         = m_valid & m_ready;
    // A pop raised while rst is high would be lost, so never raise it.
    assign can_pop    = enable & fifo_pndng & ~rst;

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        idx_d    = idx_q;
        words_d  = words_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (can_pop) begin
                    fifo_pop = 1'b1;
                    state_d  = FETCH;
                end
            end
            FETCH: begin
                shreg_d = fifo_dout;
                idx_d   = '0;
                state_d = SEND;
            end
            SEND: begin
                if (hs) begin
                    if (last_chunk) begin
                        words_d = words_q + cnt_width'(1);
                        // Chain the next pop onto the final handshake
                        // so words flow with a single FETCH bubble.
                        if (can_pop) begin
                            fifo_pop = 1'b1;
                            state_d  = FETCH;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        shreg_d = shreg_q >> out_bits;
                        idx_d   = idx_q + IW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            words_q <= words_d;
        end
    end

    // Outside SEND the stale shift register is hidden.
    assign m_data     = m_valid ? shreg_q[out_bits-1:0] : '0;
    assign m_last     = m_valid & last_chunk;
    assign words_read = words_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_drain_serializer.sv
// tb_fifo_drain_serializer: directed plus random stimulus for two
// configurations (32/8 and 32/32 with a 2-bit counter) against a chunk-queue model.
module tb_fifo_drain_serializer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        en_a = 0, pndng_a = 0, pop_a, valid_a, ready_a = 0, last_a, busy_a;
    logic [31:0] dout_a = 0;
    logic [7:0]  data_a;
    logic [15:0] wr_a;

    logic        en_b = 0, pndng_b = 0, pop_b, valid_b, ready_b = 0, last_b, busy_b;
    logic [31:0] dout_b = 0, data_b;
    logic [1:0]  wr_b;

    fifo_drain_serializer #(.bits(32), .out_bits(8), .cnt_width(16)) dut_a (
        .clk(clk), .rst(rst), .enable(en_a), .fifo_pndng(pndng_a),
        .fifo_dout(dout_a), .fifo_pop(pop_a), .m_data(data_a),
        .m_valid(valid_a), .m_ready(ready_a), .m_last(last_a),
        .words_read(wr_a), .busy(busy_a)
    );

    fifo_drain_serializer #(.bits(32), .out_bits(32), .cnt_width(2)) dut_b (
        .clk(clk), .rst(rst), .enable(en_b), .fifo_pndng(pndng_b),
        .fifo_dout(dout_b), .fifo_pop(pop_b), .m_data(data_b),
        .m_valid(valid_b), .m_ready(ready_b), .m_last(last_b),
        .words_read(wr_b), .busy(busy_b)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // FIFO contents and the expected chunk stream ({last, data}) per DUT.
    logic [31:0] qa[$], qb[$];
    logic [8:0]  ea[$];
    logic [32:0] eb[$];
    logic [15:0] exp_wr_a = 0;
    logic [1:0]  exp_wr_b = 0;
    bit          fetch_a = 0, fetch_b = 0;
    logic [31:0] dnext_a = 0, dnext_b = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_a(input logic [31:0] w);
        qa.push_back(w);
        pndng_a = 1'b1;
    endtask

    task automatic push_b(input logic [31:0] w);
        qb.push_back(w);
        pndng_b = 1'b1;
    endtask

    task automatic mon_a();
        bit ev, hs, ep;
        logic [31:0] w;
        ev = (ea.size() > 0) && !fetch_a;
        hs = ev && ready_a;
        chk("a_valid", valid_a, ev);
        chk("a_busy", busy_a, ea.size() > 0);
        chk("a_words", wr_a, exp_wr_a);
        if (ev) begin
            chk("a_data", data_a, ea[0][7:0]);
            chk("a_last", last_a, ea[0][8]);
        end
        ep = !rst && en_a && pndng_a && (ea.size() == 0 || (hs && ea.size() == 1));
        chk("a_pop", pop_a, ep);
        if (hs) begin
            if (ea.size() == 1) exp_wr_a++;
            void'(ea.pop_front());
        end
        fetch_a = 0;
        if (ep) begin
            w = qa.pop_front();
            dnext_a = w;
            for (int i = 0; i < 4; i++) ea.push_back({i == 3, w[8*i +: 8]});
            fetch_a = 1;
        end
        if (rst) begin
            ea.delete();
            fetch_a = 0;
            exp_wr_a = 0;
        end
    endtask

    task automatic mon_b();
        bit ev, hs, ep;
        logic [31:0] w;
        ev = (eb.size() > 0) && !fetch_b;
        hs = ev && ready_b;
        chk("b_valid", valid_b, ev);
        chk("b_busy", busy_b, eb.size() > 0);
        chk("b_words", wr_b, exp_wr_b);
        if (ev) begin
            chk("b_data", data_b, eb[0][31:0]);
            chk("b_last", last_b, eb[0][32]);
        end
        ep = !rst && en_b && pndng_b && (eb.size() == 0 || (hs && eb.size() == 1));
        chk("b_pop", pop_b, ep);
        if (hs) begin
            if (eb.size() == 1) exp_wr_b++;
            void'(eb.pop_front());
        end
        fetch_b = 0;
        if (ep) begin
            w = qb.pop_front();
            dnext_b = w;
            eb.push_back({1'b1, w});
            fetch_b = 1;
        end
        if (rst) begin
            eb.delete();
            fetch_b = 0;
            exp_wr_b = 0;
        end
    endtask

    // One clock: check at negedge, then update the FIFO models after posedge.
    task automatic cyc();
        @(negedge clk);
        mon_a();
        mon_b();
        @(posedge clk);
        #1;
        dout_a  = fetch_a ? dnext_a : $urandom;
        dout_b  = fetch_b ? dnext_b : $urandom;
        pndng_a = qa.size() > 0;
        pndng_b = qb.size() > 0;
    endtask

    initial begin
        // Reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", valid_a, 0);
        chk("rst_data", data_a, 0);
        chk("rst_last", last_a, 0);
        chk("rst_pop", pop_a, 0);
        chk("rst_words", wr_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_b_words", wr_b, 0);
        cyc();
        rst = 0;
        cyc();

        // Single word, full throughput
        en_a = 1;
        ready_a = 1;
        push_a(32'h44332211);
        repeat (8) cyc();
        chk("w1_words", wr_a, 1);
        chk("w1_busy", busy_a, 0);

        // Backpressure pattern 1,0,0,1,...
        push_a(32'hDEADBEEF);
        for (int i = 0; i < 18; i++) begin
            ready_a = (i % 4 == 0) || (i % 4 == 3);
            cyc();
        end
        ready_a = 1;
        repeat (4) cyc();
        chk("bp_words", wr_a, 2);

        // Three queued words back to back
        push_a(32'h0A0B0C0D);
        push_a(32'h01020304);
        push_a(32'hFFFFFFFF);
        repeat (18) cyc();
        chk("q3_words", wr_a, 5);

        // Drop enable on the 2nd chunk
        push_a($urandom);
        push_a($urandom);
        for (int k = 0; k < 20 && !(ea.size() == 3 && !fetch_a); k++) cyc();
        chk("en_wait", ea.size(), 3);
        en_a = 0;
        repeat (6) cyc();
        chk("en_park_busy", busy_a, 0);
        chk("en_park_words", wr_a, 6);
        en_a = 1;
        #1;
        chk("en_reen_pop", pop_a, 1);
        repeat (8) cyc();
        chk("en_done_words", wr_a, 7);

        // Reset during the 3rd chunk
        push_a($urandom);
        for (int k = 0; k < 20 && !(ea.size() == 2 && !fetch_a); k++) cyc();
        chk("rst_wait", ea.size(), 2);
        rst = 1;
        cyc();
        rst = 0;
        #1;
        chk("mid_rst_valid", valid_a, 0);
        chk("mid_rst_data", data_a, 0);
        chk("mid_rst_last", last_a, 0);
        chk("mid_rst_words", wr_a, 0);
        chk("mid_rst_busy", busy_a, 0);
        chk("mid_rst_pop", pop_a, 0);
        push_a(32'hCAFEF00D);
        #1;
        chk("post_rst_pop", pop_a, 1);
        repeat (8) cyc();
        chk("post_rst_words", wr_a, 1);

        // N=1 configuration, 2-bit counter wraps
        en_b = 1;
        ready_b = 1;
        for (int i = 0; i < 5; i++) push_b($urandom);
        repeat (14) cyc();
        chk("b_wrap_words", wr_b, 1);

        // Random traffic on both instances
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) push_a($urandom);
            if ($urandom_range(0, 3) == 0) push_b($urandom);
            ready_a = 1'($urandom_range(0, 1));
            ready_b = 1'($urandom_range(0, 1));
            en_a = $urandom_range(0, 7) != 0;
            en_b = $urandom_range(0, 7) != 0;
            cyc();
        end
        en_a = 1;
        en_b = 1;
        ready_a = 1;
        ready_b = 1;
        for (int k = 0; k < 3000; k++) begin
            if (qa.size() == 0 && ea.size() == 0 && qb.size() == 0 && eb.size() == 0) break;
            cyc();
        end
        cyc();
        chk("drain_a", ea.size() + qa.size(), 0);
        chk("drain_b", eb.size() + qb.size(), 0);
        chk("drain_busy_a", busy_a, 0);
        chk("drain_busy_b", busy_b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
